// File: rtl/lagarto0_pkg.sv
// Shared types and constants for the lagarto0 instruction-fetch path.
// Holds the icache refill FSM states, line/beat geometry and the fill payload.
package lagarto0_pkg;

   localparam int unsigned ADDR_SIZE        = 32;
   localparam int unsigned LINE_BITS        = 64;
   localparam int unsigned BEAT_BITS        = 32;
   localparam int unsigned REFILL_BEATS     = LINE_BITS / BEAT_BITS;
   localparam int unsigned LINE_OFFSET_BITS = 3;
   localparam int unsigned BEAT_IDX_BITS    = (REFILL_BEATS > 1) ? $clog2(REFILL_BEATS) : 1;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, FILL, ERR} refill_state_t;

   typedef struct packed {
      logic [ADDR_SIZE-1:0] addr;
      logic [LINE_BITS-1:0] line;
   } fill_req_t;

   // Clear the byte-within-line offset of an address.
   function automatic logic [ADDR_SIZE-1:0] line_align(input logic [ADDR_SIZE-1:0] a);
      return a & ~ADDR_SIZE'((1 << LINE_OFFSET_BITS) - 1);
   endfunction

endpackage

// File: rtl/refill_linebuf.sv
// Beat index and line assembly buffer for the icache refill sequencer.
// Beat b lands in line[b*BEAT_BITS +: BEAT_BITS]; beat 0 is the low word.
module refill_linebuf
   import lagarto0_pkg::*;
(
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_clr,
   input  logic                     i_load,
   input  logic [BEAT_BITS-1:0]     i_data,
   output logic [BEAT_IDX_BITS-1:0] o_beat,
   output logic                     o_last,
   output logic [LINE_BITS-1:0]     o_line_ins_c
);

   logic [BEAT_IDX_BITS-1:0] r_beat;
   logic [LINE_BITS-1:0]     r_line;
   logic [LINE_BITS-1:0]     w_line_ins;

   // Current buffer with the incoming beat merged at the current index.
   always_comb begin
      w_line_ins = r_line;
      for (int unsigned b = 0; b < REFILL_BEATS; b++) begin
         if (r_beat == BEAT_IDX_BITS'(b)) begin
            w_line_ins[b*BEAT_BITS +: BEAT_BITS] = i_data;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_beat <= '0;
         r_line <= '0;
      end else if (i_load) begin
         r_line <= w_line_ins;
         if (!o_last) begin
            r_beat <= r_beat + BEAT_IDX_BITS'(1);
         end
      end
   end

   assign o_beat       = r_beat;
   assign o_last       = (r_beat == BEAT_IDX_BITS'(REFILL_BEATS - 1));
   assign o_line_ins_c = w_line_ins;

endmodule

// File: rtl/icache_refill_ctrl.sv
// L1 icache miss handler: stalls fetch, reads the line in beats and fills the icache.
// Define ICACHE_PERF_CNT_EN to build the saturating miss counter on miss_cnt_o.
module icache_refill_ctrl
   import lagarto0_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_valid_i,
   input  logic [ADDR_SIZE-1:0] req_pc_i,
   input  logic                 hit_i,
   output logic                 stall_o,
   output logic                 mem_req_o,
   output logic [ADDR_SIZE-1:0] mem_addr_o,
   input  logic                 mem_gnt_i,
   input  logic                 mem_rvalid_i,
   input  logic [BEAT_BITS-1:0] mem_rdata_i,
   input  logic                 mem_err_i,
   output logic                 fill_we_o,
   output logic [ADDR_SIZE-1:0] fill_addr_o,
   output logic [LINE_BITS-1:0] fill_line_o,
   output logic                 busy_o,
   output logic                 err_o,
   output logic [31:0]          miss_cnt_o
);

   refill_state_t            r_state, w_state_nxt;
   logic [ADDR_SIZE-1:0]     r_line_addr;
   logic                     r_err;
   logic                     r_fill_we;
   fill_req_t                r_fill;
   logic                     w_miss, w_start, w_load, w_set_err, w_to_fill, w_last;
   logic [BEAT_IDX_BITS-1:0] w_beat;
   logic [LINE_BITS-1:0]     w_line_ins;

   assign w_miss = req_valid_i & ~hit_i;

   refill_linebuf u_linebuf (
      .i_clk        (clk_i),
      .i_rst        (rst_i),
      .i_clr        (w_start),
      .i_load       (w_load),
      .i_data       (mem_rdata_i),
      .o_beat       (w_beat),
      .o_last       (w_last),
      .o_line_ins_c (w_line_ins)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state; responses are only accepted while waiting on a granted beat.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_load      = 1'b0;
      w_set_err   = 1'b0;
      w_to_fill   = 1'b0;
      case (r_state)
         IDLE: if (w_miss) begin
            w_start     = 1'b1;
            w_state_nxt = REQ;
         end
         REQ:  if (mem_gnt_i) w_state_nxt = WAIT;
         WAIT: if (mem_rvalid_i) begin
            if (mem_err_i) begin
               w_set_err   = 1'b1;
               w_state_nxt = ERR;
            end else begin
               w_load = 1'b1;
               if (w_last) begin
                  w_to_fill   = 1'b1;
                  w_state_nxt = FILL;
               end else begin
                  w_state_nxt = REQ;
               end
            end
         end
         FILL:    w_state_nxt = IDLE;
         ERR:     w_state_nxt = ERR;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Fill payload is captured once and held until the next refill completes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_line_addr <= '0;
         r_err       <= 1'b0;
         r_fill_we   <= 1'b0;
         r_fill      <= '0;
      end else begin
         if (w_start) r_line_addr <= line_align(req_pc_i);
         r_err     <= r_err | w_set_err;
         r_fill_we <= w_to_fill;
         if (w_to_fill) r_fill <= '{addr: r_line_addr, line: w_line_ins};
      end
   end

   assign stall_o     = w_miss | (r_state != IDLE);
   assign busy_o      = (r_state != IDLE);
   assign mem_req_o   = (r_state == REQ);
   assign mem_addr_o  = mem_req_o ? (r_line_addr + (ADDR_SIZE'(w_beat) << 2)) : '0;
   assign fill_we_o   = r_fill_we;
   assign fill_addr_o = r_fill.addr;
   assign fill_line_o = r_fill.line;
   assign err_o       = r_err;

`ifdef ICACHE_PERF_CNT_EN
   logic [31:0] r_miss_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_miss_cnt <= '0;
      end else if (w_start && (r_miss_cnt != 32'hFFFF_FFFF)) begin
         r_miss_cnt <= r_miss_cnt + 32'd1;
      end
   end

   assign miss_cnt_o = r_miss_cnt;
`else
   assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: directed scenarios plus randomized
// refills with random grant/response latency, compared against a transaction-level model.
module tb_icache_refill_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        req_valid_i = 1'b0;
   logic [31:0] req_pc_i = '0;
   logic        hit_i = 1'b0;
   logic        stall_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_gnt_i = 1'b0;
   logic        mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   logic        mem_err_i = 1'b0;
   logic        fill_we_o;
   logic [31:0] fill_addr_o;
   logic [63:0] fill_line_o;
   logic        busy_o;
   logic        err_o;
   logic [31:0] miss_cnt_o;

   int          n_cmp = 0;
   int          n_mis = 0;
   int unsigned m_miss = 0;

   always #5 clk_i = ~clk_i;

   icache_refill_ctrl dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid_i),
      .req_pc_i     (req_pc_i),
      .hit_i        (hit_i),
      .stall_o      (stall_o),
      .mem_req_o    (mem_req_o),
      .mem_addr_o   (mem_addr_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .mem_err_i    (mem_err_i),
      .fill_we_o    (fill_we_o),
      .fill_addr_o  (fill_addr_o),
      .fill_line_o  (fill_line_o),
      .busy_o       (busy_o),
      .err_o        (err_o),
      .miss_cnt_o   (miss_cnt_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] exp_cnt();
`ifdef ICACHE_PERF_CNT_EN
      return 64'(m_miss);
`else
      return 64'd0;
`endif
   endfunction

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1; req_valid_i = 1'b0; hit_i = 1'b0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
      next_cycle();
      next_cycle();
      rst_i = 1'b0;
      m_miss = 0;
      @(negedge clk_i);
      chk("rst_stall", stall_o, 0);
      chk("rst_mreq", mem_req_o, 0);
      chk("rst_maddr", mem_addr_o, 0);
      chk("rst_fwe", fill_we_o, 0);
      chk("rst_faddr", fill_addr_o, 0);
      chk("rst_fline", fill_line_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_cnt", miss_cnt_o, 0);
      next_cycle();
   endtask

   // One miss handled end to end; err_beat < 0 means no bus error.
   task automatic run_miss(input logic [31:0] pc, input logic [31:0] d0, input logic [31:0] d1,
                           input int max_gd, input int max_rd, input int err_beat);
      logic [31:0] base;
      logic [31:0] data [2];
      logic [31:0] fa_prev;
      logic [63:0] fl_prev;
      int          gd;
      int          rd;
      base    = pc & 32'hFFFF_FFF8;
      data[0] = d0;
      data[1] = d1;
      fa_prev = fill_addr_o;
      fl_prev = fill_line_o;
      req_valid_i = 1'b1; hit_i = 1'b0; req_pc_i = pc;
      @(negedge clk_i);
      chk("miss_stall", stall_o, 1);
      chk("miss_busy", busy_o, 0);
      chk("miss_mreq", mem_req_o, 0);
      next_cycle();
      m_miss++;
      for (int b = 0; b < 2; b++) begin
         gd = $urandom_range(0, max_gd);
         for (int k = 0; k <= gd; k++) begin
            req_pc_i     = $urandom;
            hit_i        = 1'($urandom_range(0, 1));
            mem_gnt_i    = (k == gd);
            mem_rvalid_i = 1'($urandom_range(0, 1));
            mem_rdata_i  = $urandom;
            mem_err_i    = 1'($urandom_range(0, 1));
            @(negedge clk_i);
            chk("req_mreq", mem_req_o, 1);
            chk("req_maddr", mem_addr_o, base + 32'(4 * b));
            chk("req_stall", stall_o, 1);
            chk("req_fwe", fill_we_o, 0);
            chk("req_err", err_o, 0);
            chk("req_fhold", fill_addr_o, fa_prev);
            next_cycle();
         end
         mem_gnt_i = 1'b0;
         rd = $urandom_range(0, max_rd);
         for (int k = 0; k <= rd; k++) begin
            mem_rvalid_i = (k == rd);
            mem_rdata_i  = (k == rd) ? data[b] : $urandom;
            mem_err_i    = (k == rd) ? (b == err_beat) : 1'($urandom_range(0, 1));
            @(negedge clk_i);
            chk("wait_mreq", mem_req_o, 0);
            chk("wait_stall", stall_o, 1);
            chk("wait_busy", busy_o, 1);
            chk("wait_fwe", fill_we_o, 0);
            next_cycle();
         end
         mem_rvalid_i = 1'b0;
         mem_err_i    = 1'b0;
         if (b == err_beat) begin
            for (int k = 0; k < 4; k++) begin
               hit_i       = 1'($urandom_range(0, 1));
               req_valid_i = 1'($urandom_range(0, 1));
               @(negedge clk_i);
               chk("err_flag", err_o, 1);
               chk("err_stall", stall_o, 1);
               chk("err_busy", busy_o, 1);
               chk("err_fwe", fill_we_o, 0);
               chk("err_mreq", mem_req_o, 0);
               next_cycle();
            end
            return;
         end
      end
      hit_i = 1'b0;
      @(negedge clk_i);
      chk("fill_we", fill_we_o, 1);
      chk("fill_addr", fill_addr_o, base);
      chk("fill_line", fill_line_o, {data[1], data[0]});
      chk("fill_stall", stall_o, 1);
      next_cycle();
      req_pc_i = pc; hit_i = 1'b1; req_valid_i = 1'b1;
      @(negedge clk_i);
      chk("post_stall", stall_o, 0);
      chk("post_fwe", fill_we_o, 0);
      chk("post_busy", busy_o, 0);
      chk("post_faddr", fill_addr_o, base);
      chk("post_fline", fill_line_o, {data[1], data[0]});
      chk("post_cnt", miss_cnt_o, exp_cnt());
      next_cycle();
      req_valid_i = 1'b0; hit_i = 1'b0;
   endtask

   task automatic hit_cycles(input int n, input logic [31:0] first_pc);
      for (int k = 0; k < n; k++) begin
         req_valid_i = 1'b1; hit_i = 1'b1;
         req_pc_i = (k == 0) ? first_pc : $urandom;
         @(negedge clk_i);
         chk("hit_stall", stall_o, 0);
         chk("hit_mreq", mem_req_o, 0);
         chk("hit_busy", busy_o, 0);
         next_cycle();
      end
      req_valid_i = 1'b0; hit_i = 1'b0;
      @(negedge clk_i);
      chk("idle_stall", stall_o, 0);
      next_cycle();
   endtask

   initial begin
      do_reset();

      hit_cycles(4, 32'h0000_0100);

      run_miss(32'h0000_0104, 32'h1111_1111, 32'h2222_2222, 0, 0, -1);
      run_miss(32'hFFFF_FFFC, $urandom, $urandom, 3, 2, -1);

      for (int i = 0; i < 10; i++) begin
         run_miss($urandom, $urandom, $urandom, 3, 3, -1);
         hit_cycles($urandom_range(1, 3), $urandom);
      end

      run_miss(32'h0000_0420, $urandom, $urandom, 2, 2, 1);
      do_reset();

      // Reset while waiting on beat 0, then a late response must be ignored.
      req_valid_i = 1'b1; hit_i = 1'b0; req_pc_i = 32'h0000_0340;
      next_cycle();
      mem_gnt_i = 1'b1;
      next_cycle();
      mem_gnt_i = 1'b0;
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("mid_busy", busy_o, 1);
      next_cycle();
      rst_i = 1'b0; req_valid_i = 1'b0;
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
      m_miss = 0;
      @(negedge clk_i);
      chk("mid_stall", stall_o, 0);
      chk("mid_mreq", mem_req_o, 0);
      chk("mid_maddr", mem_addr_o, 0);
      chk("mid_fwe", fill_we_o, 0);
      chk("mid_busy0", busy_o, 0);
      chk("mid_err", err_o, 0);
      chk("mid_cnt", miss_cnt_o, exp_cnt());
      next_cycle();
      mem_rvalid_i = 1'b0;
      @(negedge clk_i);
      chk("late_busy", busy_o, 0);
      chk("late_fwe", fill_we_o, 0);
      next_cycle();
      run_miss(32'h0000_0200, $urandom, $urandom, 1, 1, -1);
      run_miss(32'h0000_0300, $urandom, $urandom, 1, 1, -1);
      run_miss(32'h0000_0408, $urandom, $urandom, 1, 1, -1);
      chk("cnt_three", miss_cnt_o, exp_cnt());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
Miss handler and refill sequencer for the L1 instruction cache. It watches the fetch lookup (PC plus icache hit) and stalls fetch on a miss. It fetches the 64-bit line from a 32-bit memory port in two request/response beats, then writes the line into the icache through its fill port. It sits between fetch, icache and the external instruction memory bus, and replaces the hard-wired we_i=0 / inst_i=0 fill tie-off.

Parameters:
ADDR_SIZE, 32, width of PC and memory addresses (same value as the package constant).
LINE_BITS, 64, icache line width (one instblock).
BEAT_BITS, 32, memory data bus width; beats per line = LINE_BITS/BEAT_BITS = 2.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
req_valid_i  in  1  fetch is performing a lookup this cycle
req_pc_i  in  ADDR_SIZE  PC being looked up
hit_i  in  1  icache hit for req_pc_i (combinational from icache)
stall_o  out  1  hold the fetch PC this cycle
mem_req_o  out  1  memory read request
mem_addr_o  out  ADDR_SIZE  word address of the current beat
mem_gnt_i  in  1  memory accepted the request
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  BEAT_BITS  read data
mem_err_i  in  1  bus error, qualified by mem_rvalid_i
fill_we_o  out  1  icache line write strobe (one cycle)
fill_addr_o  out  ADDR_SIZE  line-aligned fill address
fill_line_o  out  LINE_BITS  assembled line
busy_o  out  1  FSM not in IDLE
err_o  out  1  sticky bus-error flag
miss_cnt_o  out  32  miss counter (optional feature)

Behaviour:
- Reset values: state IDLE, beat=0, line buffer 0, all outputs 0. Reset mid-refill aborts at once; mem_req_o drops the same edge; responses that arrive later are ignored.
- miss = req_valid_i & ~hit_i.
- stall_o = (state==IDLE & miss) | (state!=IDLE). It is combinational, so fetch holds the PC from the miss cycle onward.
- IDLE: on miss, latch line_addr = {req_pc_i[ADDR_SIZE-1:3], 3'b0} and set beat=0, then go to REQ.
- REQ: mem_req_o=1 and mem_addr_o = line_addr + 4*beat. Both are held stable until mem_gnt_i=1; then go to WAIT.
- WAIT: mem_req_o=0. mem_rvalid_i is accepted only in WAIT (earliest one cycle after grant); rvalid in any other state is ignored.
  - On rvalid with ~mem_err_i: beat b is written to line[b*32+:32] (beat0 is the low word, little-endian). If b was the last beat, go to FILL; otherwise increment beat and go to REQ.
  - On rvalid with mem_err_i: set err_o and go to ERR.
- FILL: fill_we_o=1 for exactly one cycle, with fill_addr_o=line_addr and fill_line_o=buffer; then go to IDLE. The icache reports hit_i the cycle after FILL, so stall releases there.
- ERR: terminal until rst_i. stall_o=1, busy_o=1, err_o=1, no fill.
- Minimum miss penalty with gnt in REQ and rvalid on the first WAIT cycle is 6 cycles: IDLE(miss), REQ, WAIT, REQ, WAIT, FILL; fetch resumes in cycle 7.
- A req_pc_i change during refill is ignored; the latched line_addr is used.
- A hit in IDLE gives zero added latency and no memory traffic.
- mem_addr_o wraps modulo 2^ADDR_SIZE.
- fill_addr_o and fill_line_o hold their last values outside FILL.

Optional Feature:
ICACHE_PERF_CNT_EN
- Defined: miss_cnt_o increments by 1 on each IDLE->REQ transition, saturates at 32'hFFFF_FFFF, and clears on rst_i.
- Undefined: the counter is not built and miss_cnt_o is tied to 0. The port list is unchanged.

Decomposition:
- lagarto0_pkg gains:
  - typedef enum logic [2:0] refill_state_t {IDLE, REQ, WAIT, FILL, ERR};
  - localparam LINE_BITS=64, BEAT_BITS=32, REFILL_BEATS=LINE_BITS/BEAT_BITS;
  - localparam LINE_OFFSET_BITS=3.
- One sub-module, refill_linebuf: the beat index register plus the line shift/insert buffer, with load, clear and last-beat outputs.
- The FSM and stall logic stay in the top module.

Test Plan:
- Hit path: req_valid_i=1, hit_i=1, pc=0x100 -> stall_o=0, mem_req_o never asserted, busy_o=0.
- Miss with zero-wait memory: pc=0x104, hit_i=0; gnt immediate; rdata 0x11111111 then 0x22222222 -> mem_addr_o 0x100 then 0x104; in cycle 6 fill_we_o=1, fill_addr_o=0x100, fill_line_o=0x22222222_11111111; stall_o low in cycle 7.
- Delayed grant/response: gnt held low 3 cycles, rvalid 2 cycles late -> mem_req_o and mem_addr_o stay stable until gnt; exactly two requests are issued; exactly one fill_we_o pulse.
- Bus error on beat 1: mem_err_i=1 with rvalid -> err_o=1 and stays 1, fill_we_o never pulses, stall_o stays 1 until rst_i.
- Reset mid-refill: rst_i asserted in WAIT of beat 0 -> next cycle state IDLE, all outputs 0; a late rvalid is ignored; a new miss at 0x200 refills correctly.
- With ICACHE_PERF_CNT_EN defined: three distinct misses -> miss_cnt_o=3. Without it, miss_cnt_o=0 throughout.
